alu_issue_ctrl: RTL and testbench

//  Request-side controller for the datapath ALU: accepts one operation per valid/ready handshake and packs the operands onto the ALU ports.

---
 rtl/alu_issue_ctrl_if.sv | 38 +++
 rtl/alu_issue_ctrl.sv | 127 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Request/response channel between the issue stage and alu_issue_ctrl.
// Optional rsp_illegal exists only when ALU_ISSUE_ILLEGAL_EN is defined.
interface alu_issue_ctrl_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int CTRL_WIDTH   = 5,
    parameter int STATUS_WIDTH = 4,
    parameter int SHAMT_WIDTH  = 5
);
    logic                    req_valid;
    logic                    req_ready;
    logic [DATA_WIDTH-1:0]   req_a;
    logic [DATA_WIDTH-1:0]   req_b;
    logic [CTRL_WIDTH-1:0]   req_ctrl;
    logic [SHAMT_WIDTH-1:0]  req_shamt;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [DATA_WIDTH-1:0]   rsp_data;
    logic [STATUS_WIDTH-1:0] rsp_status;
`ifdef ALU_ISSUE_ILLEGAL_EN
    logic                    rsp_illegal;
`endif

    modport master (
        output req_valid, req_a, req_b, req_ctrl, req_shamt, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_status
`ifdef ALU_ISSUE_ILLEGAL_EN
        , input rsp_illegal
`endif
    );

    modport slave (
        input  req_valid, req_a, req_b, req_ctrl, req_shamt, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_status
`ifdef ALU_ISSUE_ILLEGAL_EN
        , output rsp_illegal
`endif
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the datapath ALU: one op per handshake, waits ALU_LAT edges, returns result/status.
// Define ALU_ISSUE_ILLEGAL_EN to reject opcodes above 5'h11 without enabling the ALU.
module alu_issue_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int CTRL_WIDTH   = 5,
    parameter int STATUS_WIDTH = 4,
    parameter int SHAMT_WIDTH  = 5,
    parameter int ALU_LAT      = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    alu_issue_ctrl_if.slave           bus,
    output logic                      busy,
    output logic                      alu_en_n,
    output logic [2*DATA_WIDTH-1:0]   alu_dataIn,
    output logic [CTRL_WIDTH-1:0]     alu_ctrl,
    output logic [SHAMT_WIDTH-1:0]    alu_shamt,
    input  logic [DATA_WIDTH-1:0]     alu_dataOut,
    input  logic [STATUS_WIDTH-1:0]   alu_status
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Counter preload so the capture lands exactly ALU_LAT edges after issue.
    localparam logic [7:0] CNT_INIT = 8'(ALU_LAT - 1);

    state_t                    state_reg;
    logic [7:0]                cnt_reg;
    logic                      alu_en_n_reg;
    logic [2*DATA_WIDTH-1:0]   alu_data_in_reg;
    logic [CTRL_WIDTH-1:0]     alu_ctrl_reg;
    logic [SHAMT_WIDTH-1:0]    alu_shamt_reg;
    logic                      rsp_valid_reg;
    logic [DATA_WIDTH-1:0]     rsp_data_reg;
    logic [STATUS_WIDTH-1:0]   rsp_status_reg;
    logic                      accept;
`ifdef ALU_ISSUE_ILLEGAL_EN
    logic                      rsp_illegal_reg;
    logic                      illegal_op;

    assign illegal_op      = bus.req_ctrl > CTRL_WIDTH'(5'h11);
    assign bus.rsp_illegal = rsp_illegal_reg;
`endif

    assign bus.req_ready  = (state_reg == ST_IDLE) & ~rst;
    assign accept         = bus.req_valid & bus.req_ready;
    assign busy           = (state_reg != ST_IDLE);
    assign alu_en_n       = alu_en_n_reg;
    assign alu_dataIn     = alu_data_in_reg;
    assign alu_ctrl       = alu_ctrl_reg;
    assign alu_shamt      = alu_shamt_reg;
    assign bus.rsp_valid  = rsp_valid_reg;
    assign bus.rsp_data   = rsp_data_reg;
    assign bus.rsp_status = rsp_status_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            alu_en_n_reg    <= 1'b1;
            alu_data_in_reg <= '0;
            alu_ctrl_reg    <= '0;
            alu_shamt_reg   <= '0;
            rsp_valid_reg   <= 1'b0;
            rsp_data_reg    <= '0;
            rsp_status_reg  <= '0;
`ifdef ALU_ISSUE_ILLEGAL_EN
            rsp_illegal_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        alu_data_in_reg <= {bus.req_a, bus.req_b};
                        alu_ctrl_reg    <= bus.req_ctrl;
                        alu_shamt_reg   <= bus.req_shamt;
`ifdef ALU_ISSUE_ILLEGAL_EN
                        // Illegal opcodes answer immediately; the ALU stays disabled.
                        if (illegal_op) begin
                            rsp_valid_reg   <= 1'b1;
                            rsp_data_reg    <= '0;
                            rsp_status_reg  <= '0;
                            rsp_illegal_reg <= 1'b1;
                            state_reg       <= ST_RESP;
                        end else begin
`endif
                            alu_en_n_reg <= 1'b0;
                            cnt_reg      <= CNT_INIT;
                            state_reg    <= ST_WAIT;
`ifdef ALU_ISSUE_ILLEGAL_EN
                        end
`endif
                    end
                end
                ST_WAIT: begin
                    if (cnt_reg != 8'd0) begin
                        cnt_reg <= cnt_reg - 8'd1;
                    end else begin
                        rsp_data_reg   <= alu_dataOut;
                        rsp_status_reg <= alu_status;
                        rsp_valid_reg  <= 1'b1;
                        alu_en_n_reg   <= 1'b1;
`ifdef ALU_ISSUE_ILLEGAL_EN
                        rsp_illegal_reg <= 1'b0;
`endif
                        state_reg      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
`ifdef ALU_ISSUE_ILLEGAL_EN
                        rsp_illegal_reg <= 1'b0;
`endif
                        state_reg     <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: two instances (ALU_LAT=2 and ALU_LAT=1) driving a latency-aware ALU model.
module tb_alu_issue_ctrl;
    localparam int DW = 32;
    localparam int CW = 5;
    localparam int SW = 4;
    localparam int HW = 5;

    localparam logic [4:0] OP_AND = 5'h0;
    localparam logic [4:0] OP_OR  = 5'h1;
    localparam logic [4:0] OP_ADD = 5'h4;
    localparam logic [4:0] OP_SUB = 5'h5;
    localparam logic [4:0] OP_SLL = 5'h8;
    localparam logic [4:0] OP_SRA = 5'hA;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    alu_issue_ctrl_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .STATUS_WIDTH(SW), .SHAMT_WIDTH(HW)) bus_a ();
    alu_issue_ctrl_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .STATUS_WIDTH(SW), .SHAMT_WIDTH(HW)) bus_b ();

    logic          busy_a, en_n_a, busy_b, en_n_b;
    logic [63:0]   din_a, din_b;
    logic [4:0]    ctrl_a, shamt_a, ctrl_b, shamt_b;
    logic [31:0]   dout_a, dout_b;
    logic [3:0]    st_a, st_b;

    alu_issue_ctrl #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .STATUS_WIDTH(SW), .SHAMT_WIDTH(HW), .ALU_LAT(2)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave), .busy(busy_a), .alu_en_n(en_n_a),
        .alu_dataIn(din_a), .alu_ctrl(ctrl_a), .alu_shamt(shamt_a),
        .alu_dataOut(dout_a), .alu_status(st_a)
    );

    alu_issue_ctrl #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .STATUS_WIDTH(SW), .SHAMT_WIDTH(HW), .ALU_LAT(1)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave), .busy(busy_b), .alu_en_n(en_n_b),
        .alu_dataIn(din_b), .alu_ctrl(ctrl_b), .alu_shamt(shamt_b),
        .alu_dataOut(dout_b), .alu_status(st_b)
    );

    // ALU model: result/status {ovf,carry,sign,zero}; unknown ops return a marker.
    function automatic logic [35:0] alu_fn(input logic [63:0] din, input logic [4:0] op, input logic [4:0] sh);
        logic [31:0] a, b, r;
        logic c, v;
        a = din[63:32];
        b = din[31:0];
        c = 1'b0;
        v = 1'b0;
        case (op)
            OP_ADD: begin
                {c, r} = {1'b0, a} + {1'b0, b};
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            OP_SUB: begin
                {c, r} = {1'b0, a} - {1'b0, b};
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_SLL:  r = b << sh;
            OP_SRA:  r = $signed(b) >>> sh;
            default: r = 32'hA5A5_0000 | {27'd0, op};
        endcase
        return {v, c, r[31], (r == 32'd0), r};
    endfunction

    // Output only becomes valid after the enable has been low for LAT-1 edges.
    int mcnt_a = 0;
    int mcnt_b = 0;
    always @(posedge clk) begin
        mcnt_a <= en_n_a ? 0 : mcnt_a + 1;
        mcnt_b <= en_n_b ? 0 : mcnt_b + 1;
    end

    always_comb begin
        {st_a, dout_a} = {4'h0, 32'hDEAD_BEEF};
        if (!en_n_a && mcnt_a >= 1) {st_a, dout_a} = alu_fn(din_a, ctrl_a, shamt_a);
    end

    always_comb begin
        {st_b, dout_b} = {4'h0, 32'hDEAD_BEEF};
        if (!en_n_b) {st_b, dout_b} = alu_fn(din_b, ctrl_b, shamt_b);
    end

    int          hs_q[$];
    logic [31:0] rsp_q[$];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus_a.req_valid && bus_a.req_ready) hs_q.push_back(cyc);
        if (bus_a.rsp_valid && bus_a.rsp_ready) rsp_q.push_back(bus_a.rsp_data);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op, input logic [4:0] sh);
        bus_a.req_a     = a;
        bus_a.req_b     = b;
        bus_a.req_ctrl  = op;
        bus_a.req_shamt = sh;
    endtask

    // Handshake one request on instance A; returns 1 ns after the accepting edge.
    task automatic issue_a(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op, input logic [4:0] sh);
        int n;
        n = 0;
        drive_a(a, b, op, sh);
        bus_a.req_valid = 1'b1;
        while (!bus_a.req_ready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check("issue_timeout", 64'(0), 64'(1));
        tick();
        bus_a.req_valid = 1'b0;
    endtask

    task automatic run_a(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op, input logic [4:0] sh,
                         output logic [31:0] data, output logic [3:0] status);
        int n;
        issue_a(a, b, op, sh);
        n = 0;
        while (!bus_a.rsp_valid && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("rsp_timeout", 64'(0), 64'(1));
        data   = bus_a.rsp_data;
        status = bus_a.rsp_status;
        bus_a.rsp_ready = 1'b1;
        tick();
        bus_a.rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic [3:0]  s;
        int          n;

        rst = 1'b1;
        bus_a.req_valid = 1'b0; bus_a.rsp_ready = 1'b0; drive_a('0, '0, '0, '0);
        bus_b.req_valid = 1'b0; bus_b.rsp_ready = 1'b0;
        bus_b.req_a = '0; bus_b.req_b = '0; bus_b.req_ctrl = '0; bus_b.req_shamt = '0;
        bus_a.req_valid = 1'b1;
        repeat (2) tick();

        // Reset state
        check("rst_req_ready", 64'(bus_a.req_ready), 64'(0));
        check("rst_alu_en_n", 64'(en_n_a), 64'(1));
        check("rst_rsp_valid", 64'(bus_a.rsp_valid), 64'(0));
        check("rst_busy", 64'(busy_a), 64'(0));
        check("rst_alu_dataIn", din_a, 64'(0));
        check("rst_rsp_data", 64'(bus_a.rsp_data), 64'(0));
        bus_a.req_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("post_rst_req_ready", 64'(bus_a.req_ready), 64'(1));

        // T1 add 5+3 with latency 2
        issue_a(32'h5, 32'h3, OP_ADD, 5'd0);
        check("t1_alu_dataIn", din_a, 64'h0000_0005_0000_0003);
        check("t1_ctrl", 64'(ctrl_a), 64'(OP_ADD));
        check("t1_en_n_e0", 64'(en_n_a), 64'(0));
        check("t1_req_ready_busy", 64'(bus_a.req_ready), 64'(0));
        check("t1_rsp_valid_e0", 64'(bus_a.rsp_valid), 64'(0));
        tick();
        check("t1_en_n_e1", 64'(en_n_a), 64'(0));
        check("t1_rsp_valid_e1", 64'(bus_a.rsp_valid), 64'(0));
        tick();
        check("t1_rsp_valid_e2", 64'(bus_a.rsp_valid), 64'(1));
        check("t1_rsp_data", 64'(bus_a.rsp_data), 64'h8);
        check("t1_rsp_status", 64'(bus_a.rsp_status), 64'h0);
        check("t1_en_n_e2", 64'(en_n_a), 64'(1));
`ifdef ALU_ISSUE_ILLEGAL_EN
        check("t1_rsp_illegal", 64'(bus_a.rsp_illegal), 64'(0));
`endif
        bus_a.rsp_ready = 1'b1;
        tick();
        bus_a.rsp_ready = 1'b0;
        check("t1_rsp_valid_cleared", 64'(bus_a.rsp_valid), 64'(0));
        check("t1_idle", 64'(busy_a), 64'(0));

        // T2 sub 7-7 under backpressure
        issue_a(32'h7, 32'h7, OP_SUB, 5'd0);
        repeat (2) tick();
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_valid", 64'(bus_a.rsp_valid), 64'(1));
            check("t2_hold_data", 64'(bus_a.rsp_data), 64'h0);
            check("t2_hold_zero", 64'(bus_a.rsp_status[0]), 64'(1));
            check("t2_req_ready", 64'(bus_a.req_ready), 64'(0));
            tick();
        end
        bus_a.rsp_ready = 1'b1;
        tick();
        bus_a.rsp_ready = 1'b0;
        check("t2_idle", 64'(busy_a), 64'(0));
        check("t2_rsp_valid", 64'(bus_a.rsp_valid), 64'(0));

        // T3 back-to-back with req_valid held high
        hs_q.delete();
        rsp_q.delete();
        bus_a.rsp_ready = 1'b1;
        drive_a(32'hF0, 32'h3C, OP_AND, 5'd0);
        bus_a.req_valid = 1'b1;
        tick();
        drive_a(32'hF0, 32'h0F, OP_OR, 5'd0);
        n = 0;
        while (hs_q.size() < 2 && n < 20) begin
            tick();
            n++;
        end
        bus_a.req_valid = 1'b0;
        n = 0;
        while (rsp_q.size() < 2 && n < 20) begin
            tick();
            n++;
        end
        bus_a.rsp_ready = 1'b0;
        if (hs_q.size() >= 2 && rsp_q.size() >= 2) begin
            check("t3_hs_spacing", 64'(hs_q[1] - hs_q[0]), 64'(4));
            check("t3_rsp0", 64'(rsp_q[0]), 64'h30);
            check("t3_rsp1", 64'(rsp_q[1]), 64'hFF);
        end else begin
            check("t3_counts", 64'(rsp_q.size()), 64'(2));
        end

        // T4 reset in the middle of WAIT
        issue_a(32'h0, 32'h1, OP_SLL, 5'd4);
        rst = 1'b1;
        tick();
        check("t4_idle", 64'(busy_a), 64'(0));
        check("t4_en_n", 64'(en_n_a), 64'(1));
        check("t4_rsp_valid", 64'(bus_a.rsp_valid), 64'(0));
        check("t4_req_ready_in_rst", 64'(bus_a.req_ready), 64'(0));
        rst = 1'b0;
        rsp_q.delete();
        bus_a.rsp_ready = 1'b1;
        repeat (6) tick();
        bus_a.rsp_ready = 1'b0;
        check("t4_no_response", 64'(rsp_q.size()), 64'(0));
        run_a(32'h0, 32'h1, OP_SLL, 5'd4, d, s);
        check("t4_next_op", 64'(d), 64'h10);

        // mthi still returns a response carrying the ALU's output
        run_a(32'h1, 32'h2, 5'hd, 5'd0, d, s);
        check("mthi_rsp", 64'(d), 64'hA5A5_000D);

        // T5 latency 1, arithmetic shift right
        check("t5_ready", 64'(bus_b.req_ready), 64'(1));
        bus_b.req_a = 32'h0; bus_b.req_b = 32'h8000_0000; bus_b.req_ctrl = OP_SRA; bus_b.req_shamt = 5'd31;
        bus_b.req_valid = 1'b1;
        tick();
        bus_b.req_valid = 1'b0;
        check("t5_en_n_e0", 64'(en_n_b), 64'(0));
        check("t5_rsp_valid_e0", 64'(bus_b.rsp_valid), 64'(0));
        tick();
        check("t5_rsp_valid_e1", 64'(bus_b.rsp_valid), 64'(1));
        check("t5_rsp_data", 64'(bus_b.rsp_data), 64'hFFFF_FFFF);
        check("t5_sign", 64'(bus_b.rsp_status[1]), 64'(1));
        check("t5_en_n_e1", 64'(en_n_b), 64'(1));
        bus_b.rsp_ready = 1'b1;
        tick();
        bus_b.rsp_ready = 1'b0;
        check("t5_rsp_cleared", 64'(bus_b.rsp_valid), 64'(0));

`ifdef ALU_ISSUE_ILLEGAL_EN
        // T6 illegal opcode is answered without enabling the ALU
        issue_a(32'h12, 32'h34, 5'h1F, 5'd0);
        check("t6_en_n", 64'(en_n_a), 64'(1));
        check("t6_rsp_valid", 64'(bus_a.rsp_valid), 64'(1));
        check("t6_rsp_illegal", 64'(bus_a.rsp_illegal), 64'(1));
        check("t6_rsp_data", 64'(bus_a.rsp_data), 64'h0);
        check("t6_rsp_status", 64'(bus_a.rsp_status), 64'h0);
        bus_a.rsp_ready = 1'b1;
        tick();
        bus_a.rsp_ready = 1'b0;
        check("t6_illegal_cleared", 64'(bus_a.rsp_illegal), 64'(0));
`else
        // Without the illegal check, 5'h1F goes to the ALU like any opcode
        run_a(32'h12, 32'h34, 5'h1F, 5'd0, d, s);
        check("op1f_issued", 64'(d), 64'hA5A5_001F);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
